// File: rtl/seq_det_pkg.sv
// ============================================================
// seq_det_pkg : shared state encoding and config helpers
// Rev 1.0
// ============================================================
`default_nettype none

package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_UNCFG  = 2'b00,
        ST_FILL   = 2'b01,
        ST_DETECT = 2'b10
    } state_t;

    function automatic logic len_legal(input int len, input int pat_w);
        return (len >= 1) && (len <= pat_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detector_param_if.sv
// ============================================================
// seq_detector_param_if : config, stream and result signals
// Rev 1.0
// ============================================================
`default_nettype none

interface seq_detector_param_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             in_valid;
    logic             in_bit;
    logic             count_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             cfg_err;
    logic [1:0]       status;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, in_bit, count_clr,
        input  match, match_count, cfg_err, status
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, in_bit, count_clr,
        output match, match_count, cfg_err, status
    );
endinterface

`default_nettype wire

// File: rtl/seq_shift_hist.sv
// ============================================================
// seq_shift_hist : history shift register with fill counter
// Rev 1.0
// ============================================================
`default_nettype none

module seq_shift_hist #(
    parameter int PAT_W = 5,
    parameter int LEN_W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             shift,
    input  wire logic             clear,
    input  wire logic             in_bit,
    input  wire logic [LEN_W-1:0] len,
    output logic      [PAT_W-1:0] hist_shift,
    output logic                  full,
    output logic                  full_shift
);
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

    // hist_shift/full_shift show the state as it would be after accepting in_bit,
    // so the comparator can decide on the same edge that samples the bit.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], in_bit};
        fill_inc   = (fill_q >= len) ? len : fill_q + LEN_W'(1);
        full_shift = (fill_inc == len);
        full       = (fill_q == len);
        hist_d     = hist_q;
        fill_d     = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================
// seq_detector_param : runtime-programmable serial pattern detector
// Rev 1.0
// ============================================================
`default_nettype none

module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seq_detector_param_if.slave bus
);
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q, overlap_d;
    logic             match_q, match_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             load_ok, shift, hit, hist_clr, full, full_shift;
    logic [PAT_W-1:0] hist_shift, mask;

    seq_shift_hist #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift      (shift),
        .clear      (hist_clr),
        .in_bit     (bus.in_bit),
        .len        (len_q),
        .hist_shift (hist_shift),
        .full       (full),
        .full_shift (full_shift)
    );

    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        count_d   = count_q;

        load_ok   = bus.cfg_load && len_legal(32'(bus.cfg_len), PAT_W);
        shift     = bus.in_valid && !bus.cfg_load && (state_q != ST_UNCFG);
        hit       = shift && full_shift && (((hist_shift ^ pattern_q) & mask) == '0);
        hist_clr  = load_ok || (hit && !overlap_q);
        match_d   = hit;
        cfg_err_d = bus.cfg_load && !load_ok;

        if (load_ok) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            overlap_d = bus.cfg_overlap;
            state_d   = ST_FILL;
        end else if (state_q != ST_UNCFG) begin
            if (shift) begin
                if (hit && !overlap_q) state_d = ST_FILL;
                else if (full_shift)   state_d = ST_DETECT;
                else                   state_d = ST_FILL;
            end else begin
                state_d = full ? ST_DETECT : ST_FILL;
            end
        end

        // Clear beats a coincident match; a config load restarts the count too.
        if (load_ok || bus.count_clr) begin
            count_d = '0;
        end else if (hit && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UNCFG;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
            count_q   <= count_d;
        end
    end

    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.status      = state_q;
endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================
// tb_seq_detector_param : directed vector bench for seq_detector_param
// Rev 1.0
// ============================================================
`default_nettype none

module tb_seq_detector_param;

    logic clk;
    logic rst_n;

    seq_detector_param_if #(.PAT_W(5), .CNT_W(8)) ifa ();
    seq_detector_param_if #(.PAT_W(5), .CNT_W(2)) ifb ();

    seq_detector_param #(.PAT_W(5), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    seq_detector_param #(.PAT_W(5), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [4:0] pat;
        logic [2:0] len;
        logic       ovl;
        logic       vld;
        logic       b;
        logic       clr;
        logic       e_match;
        logic [7:0] e_cnt;
        logic       e_err;
        logic [1:0] e_st;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [1:0] S_U = 2'b00, S_F = 2'b01, S_D = 2'b10;

    task automatic add(input logic ld, input logic [4:0] pat, input logic [2:0] len,
                       input logic ovl, input logic vld, input logic b, input logic clr,
                       input logic em, input logic [7:0] ec, input logic ee, input logic [1:0] es);
        vec_t v;
        v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.vld = vld; v.b = b; v.clr = clr;
        v.e_match = em; v.e_cnt = ec; v.e_err = ee; v.e_st = es;
        tbl.push_back(v);
    endtask

    task automatic add_bit(input logic b, input logic em, input logic [7:0] ec, input logic [1:0] es);
        add(1'b0, 5'd0, 3'd0, 1'b0, 1'b1, b, 1'b0, em, ec, 1'b0, es);
    endtask

    task automatic add_idle(input logic [7:0] ec, input logic [1:0] es);
        add(1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, 1'b0, es);
    endtask

    task automatic add_cfg(input logic [4:0] pat, input logic [2:0] len, input logic ovl,
                           input logic ee, input logic [1:0] es, input logic [7:0] ec);
        add(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, 1'b0, ec, ee, es);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.cfg_load = 0; ifa.cfg_pattern = 0; ifa.cfg_len = 0; ifa.cfg_overlap = 0;
        ifa.in_valid = 0; ifa.in_bit = 0; ifa.count_clr = 0;
    endtask

    task automatic idle_b();
        ifb.cfg_load = 0; ifb.cfg_pattern = 0; ifb.cfg_len = 0; ifb.cfg_overlap = 0;
        ifb.in_valid = 0; ifb.in_bit = 0; ifb.count_clr = 0;
    endtask

    initial begin
        idle_a();
        idle_b();
        rst_n = 1'b0;

        // Unconfigured stream, then two illegal lengths
        for (int i = 0; i < 5; i++) add_bit((i == 0 || i == 4), 1'b0, 8'd0, S_U);
        add_cfg(5'b10001, 3'd0, 1'b0, 1'b1, S_U, 8'd0);
        add_idle(8'd0, S_U);
        add_cfg(5'b10001, 3'd6, 1'b0, 1'b1, S_U, 8'd0);
        add_idle(8'd0, S_U);

        // 10001, non-overlapping
        add_cfg(5'b10001, 3'd5, 1'b0, 1'b0, S_F, 8'd0);
        add_bit(1, 0, 8'd0, S_F); add_bit(0, 0, 8'd0, S_F);
        add_bit(0, 0, 8'd0, S_F); add_bit(0, 0, 8'd0, S_F);
        add_bit(1, 1, 8'd1, S_F);
        add_bit(0, 0, 8'd1, S_F); add_bit(0, 0, 8'd1, S_F);
        add_bit(0, 0, 8'd1, S_F); add_bit(1, 0, 8'd1, S_F);
        add_idle(8'd1, S_F);

        // 10001, overlapping
        add_cfg(5'b10001, 3'd5, 1'b1, 1'b0, S_F, 8'd0);
        add_bit(1, 0, 8'd0, S_F); add_bit(0, 0, 8'd0, S_F);
        add_bit(0, 0, 8'd0, S_F); add_bit(0, 0, 8'd0, S_F);
        add_bit(1, 1, 8'd1, S_D);
        add_bit(0, 0, 8'd1, S_D); add_bit(0, 0, 8'd1, S_D);
        add_bit(0, 0, 8'd1, S_D); add_bit(1, 1, 8'd2, S_D);
        add_idle(8'd2, S_D);

        // 101 of length 3, gaps between bits
        add_cfg(5'b00101, 3'd3, 1'b1, 1'b0, S_F, 8'd0);
        add_bit(1, 0, 8'd0, S_F); add_idle(8'd0, S_F);
        add_bit(0, 0, 8'd0, S_F); add_idle(8'd0, S_F);
        add_bit(1, 1, 8'd1, S_D); add_idle(8'd1, S_D);
        add_bit(0, 0, 8'd1, S_D); add_idle(8'd1, S_D);
        add_bit(1, 1, 8'd2, S_D); add_idle(8'd2, S_D);

        // Config load on the completing bit drops that bit and restarts fill
        add_bit(0, 0, 8'd2, S_D);
        add(1'b1, 5'b00101, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, S_F);
        add_bit(0, 0, 8'd0, S_F);
        add_bit(1, 0, 8'd0, S_F);
        add_bit(0, 0, 8'd0, S_D);
        add_bit(1, 1, 8'd1, S_D);

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("reset_match", 32'(ifa.match), 32'd0);
        chk("reset_count", 32'(ifa.match_count), 32'd0);
        chk("reset_err", 32'(ifa.cfg_err), 32'd0);
        chk("reset_status", 32'(ifa.status), 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            ifa.cfg_load    = tbl[i].ld;
            ifa.cfg_pattern = tbl[i].pat;
            ifa.cfg_len     = tbl[i].len;
            ifa.cfg_overlap = tbl[i].ovl;
            ifa.in_valid    = tbl[i].vld;
            ifa.in_bit      = tbl[i].b;
            ifa.count_clr   = tbl[i].clr;
            tick();
            chk($sformatf("v%0d_match", i), 32'(ifa.match), 32'(tbl[i].e_match));
            chk($sformatf("v%0d_count", i), 32'(ifa.match_count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d_err", i), 32'(ifa.cfg_err), 32'(tbl[i].e_err));
            chk($sformatf("v%0d_status", i), 32'(ifa.status), 32'(tbl[i].e_st));
        end
        idle_a();

        // Asynchronous reset while match is high, between edges
        #3 rst_n = 1'b0;
        #1;
        chk("async_match", 32'(ifa.match), 32'd0);
        chk("async_count", 32'(ifa.match_count), 32'd0);
        chk("async_status", 32'(ifa.status), 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Saturating 2-bit counter, single-bit pattern
        ifb.cfg_load = 1; ifb.cfg_pattern = 5'b00001; ifb.cfg_len = 3'd1; ifb.cfg_overlap = 0;
        tick();
        chk("sat_cfg_status", 32'(ifb.status), 32'(S_F));
        chk("sat_cfg_count", 32'(ifb.match_count), 32'd0);
        ifb.cfg_load = 0; ifb.in_valid = 1; ifb.in_bit = 1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("sat%0d_match", k), 32'(ifb.match), 32'd1);
            chk($sformatf("sat%0d_count", k), 32'(ifb.match_count), (k < 3) ? 32'(k) : 32'd3);
        end
        ifb.count_clr = 1;
        tick();
        chk("clr_match", 32'(ifb.match), 32'd1);
        chk("clr_count", 32'(ifb.match_count), 32'd0);
        idle_b();
        tick();
        chk("post_clr_match", 32'(ifb.match), 32'd0);
        chk("post_clr_count", 32'(ifb.match_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed 5-bit detector.
- Pattern, length (1..PAT_W) and overlap mode are loaded through a config port.
- Input bits are qualified by a valid strobe; a saturating match counter is kept.
- Sits on a serial data stream: one match pulse per detected occurrence, plus a count readable by control logic.

Parameters:
PAT_W, 5, maximum pattern length in bits (>=2)
CNT_W, 8, width of the saturating match counter
LEN_W, $clog2(PAT_W+1), width of cfg_len (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  active pattern length, legal 1..PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after a match
in_valid  input  1  in_bit is sampled this cycle
in_bit  input  1  serial data bit
count_clr  input  1  synchronous clear of match_count
match  output  1  one-cycle pulse, registered
match_count  output  CNT_W  saturating number of matches since config/clear
cfg_err  output  1  one-cycle pulse: illegal cfg_len rejected
status  output  2  current FSM state encoding

Behaviour:
- Reset (rst_n low, async): state UNCFG; match=0, cfg_err=0, match_count=0, status=2'b00; history, fill, pattern, len and overlap registers all 0.
- States and encodings:
  - UNCFG=00: no valid configuration; in_valid ignored; match never asserts.
  - FILL=01: fewer than len bits accepted since config or last non-overlap match.
  - DETECT=10: fill==len; every accepted bit is compared.
- cfg_load with cfg_len in 1..PAT_W:
  - Latch pattern, len and overlap.
  - Clear history, fill and match_count.
  - Go to FILL, from any state, including mid-stream.
- cfg_load with cfg_len==0 or >PAT_W:
  - Config ignored; state, history and count unchanged.
  - cfg_err=1 for the following cycle.
- cfg_load priority: wins over in_valid in the same cycle. That bit is dropped and not shifted in.
- Accepted bit (in_valid=1, state FILL/DETECT, no cfg_load):
  - hist_n = {hist[PAT_W-2:0], in_bit}.
  - fill_n = min(fill+1, len).
  - Match condition: fill_n==len and hist_n[len-1:0]==pattern[len-1:0]. Unused high bits are never compared.
- Match latency: match=1 in the cycle after the edge that samples the completing bit; high for exactly one cycle.
- After a match:
  - overlap=1: history retained; state stays DETECT.
  - overlap=0: history and fill cleared; state returns to FILL.
- No accepted bit (in_valid=0): history, fill and state hold; match=0 next cycle.
- match_count rules:
  - Increments on each match.
  - Holds at 2^CNT_W-1 (no wrap).
  - count_clr sets it to 0. count_clr beats a simultaneous match, so the count is 0 after that edge, but match still pulses.
  - cfg_load clears it.
- FILL->DETECT when fill_n reaches len without a match, or with a match when overlap=1.

Decomposition:
- Package seq_det_pkg:
  - state enum UNCFG/FILL/DETECT with the encodings above.
  - Function len_legal(len, PAT_W).
- Sub-module seq_shift_hist:
  - PAT_W-bit history shift register plus fill counter.
  - Inputs: shift, clear, len.
  - Outputs: hist, full (fill==len).
- Top level holds the FSM, config registers, comparator and counter.

Test Plan:
1. PAT_W=5, load pattern 5'b10001, len=5, overlap=0, stream 1,0,0,0,1,0,0,0,1 -> match after bit 5 only; match_count=1; status 01 after the match.
2. Same stream with overlap=1 -> match after bits 5 and 9; match_count=2; status stays 10.
3. Pattern 5'b00101, len=3, overlap=1, stream 1,0,1,0,1 with in_valid low for one cycle between every bit -> match after bits 3 and 5, each a single-cycle pulse; count=2.
4. No config, stream 1,0,0,0,1 -> match never high; status 00. Then cfg_load with cfg_len=0 -> cfg_err pulses once; status still 00. Then cfg_len=6 -> cfg_err pulses again.
5. CNT_W=2, pattern len=1 pattern 1, stream five 1s -> match_count 1,2,3,3,3. count_clr coincident with the 6th match -> count=0 while match pulses.
6. Mid-stream checks:
   - Drop rst_n between edges -> match, count and status go to 0 without waiting for a clock.
   - cfg_load coincident with a completing bit -> no match; fill=0; status 01.
